control_unit_mc: RTL

CONTROL_UNIT_MC -- requirements
Module: control_unit_mc

---
 rtl/control_unit_mc.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit_mc.sv
// Multi-cycle RV32 subset control unit.
// Moore FSM with memory wait timeout, fault latch and retire counter.
module control_unit_mc #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             alu_src_a,
  output logic             load_reg_a,
  output logic             load_reg_b,
  output logic             load_alu_out,
  output logic             write_reg,
  output logic             load_ir,
  output logic             load_mdr,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_write,
  output logic             branch_op,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_funct,
  output logic [1:0]       mem_to_reg,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [3:0]       state_out,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [3:0] {
    FETCH      = 4'd0,
    FETCH_DONE = 4'd1,
    DECODE     = 4'd2,
    CALC_ADDR  = 4'd3,
    EXEC_R     = 4'd4,
    MEM_RD     = 4'd5,
    MEM_WR     = 4'd6,
    WB_ALU     = 4'd7,
    WB_MEM     = 4'd8,
    LUI        = 4'd9,
    BRANCH     = 4'd10,
    JAL        = 4'd11,
    FAULT      = 4'd12
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t           state, stateNext;
  logic [31:0]      waitCnt, waitCntNext;
  logic [1:0]       faultCode, faultCodeNext;
  logic [CNT_W-1:0] retireCnt;
  logic             retireInc;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [2:0] rOp;
  logic       isR, isAddr, isLui, isBr, isJal;
  logic       rLegal, brLegal, memTimeout;
  logic       unusedIr;

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign funct7   = instruction[31:25];
  assign unusedIr = ^{instruction[24:15], instruction[11:7]};

  assign isR    = opcode == OP_R;
  assign isAddr = (opcode == OP_ADDI) || (opcode == OP_LOAD) ||
                  (opcode == OP_STORE);
  assign isLui  = opcode == OP_LUI;
  assign isBr   = opcode == OP_BR;
  assign isJal  = opcode == OP_JAL;

  always_comb begin
    rOp = 3'b000;
    case ({funct7, funct3})
      10'b0000000_000: rOp = 3'b001;
      10'b0100000_000: rOp = 3'b010;
      10'b0000000_111: rOp = 3'b011;
      10'b0000000_110: rOp = 3'b100;
      default:         rOp = 3'b000;
    endcase
  end

  assign rLegal  = rOp != 3'b000;
  assign brLegal = (funct3 == 3'b000) || (funct3 == 3'b001);

  // A timeout of zero means wait forever.
  assign memTimeout = (MEM_TIMEOUT != 0) &&
                      (waitCnt == 32'(MEM_TIMEOUT - 1));

  always_comb begin
    stateNext     = state;
    waitCntNext   = waitCnt;
    faultCodeNext = faultCode;
    case (state)
      FETCH: begin
        if (imem_ready) begin
          stateNext = FETCH_DONE;
        end else if (memTimeout) begin
          stateNext     = FAULT;
          faultCodeNext = 2'b10;
        end else begin
          waitCntNext = waitCnt + 32'd1;
        end
      end
      FETCH_DONE: stateNext = DECODE;
      DECODE: begin
        unique case (1'b1)
          isR && rLegal:  stateNext = EXEC_R;
          isAddr:         stateNext = CALC_ADDR;
          isLui:          stateNext = LUI;
          isBr && brLegal: stateNext = BRANCH;
          isJal:          stateNext = JAL;
          default: begin
            if (ILLEGAL_HALT) begin
              stateNext     = FAULT;
              faultCodeNext = 2'b01;
            end else begin
              stateNext = FETCH;
            end
          end
        endcase
      end
      CALC_ADDR: begin
        if (opcode == OP_STORE)     stateNext = MEM_WR;
        else if (opcode == OP_LOAD) stateNext = MEM_RD;
        else                        stateNext = WB_ALU;
      end
      EXEC_R: stateNext = WB_ALU;
      MEM_RD, MEM_WR: begin
        if (dmem_ready) begin
          stateNext = (state == MEM_RD) ? WB_MEM : FETCH;
        end else if (memTimeout) begin
          stateNext     = FAULT;
          faultCodeNext = 2'b10;
        end else begin
          waitCntNext = waitCnt + 32'd1;
        end
      end
      WB_ALU, WB_MEM, LUI, BRANCH, JAL: stateNext = FETCH;
      FAULT:   stateNext = FAULT;
      default: stateNext = FETCH;
    endcase
    // Every wait state is entered from a different state, so any
    // transition restarts the count.
    if (stateNext != state) waitCntNext = '0;
  end

  assign retireInc = (stateNext == FETCH) && (state != FETCH) &&
                     (state != FAULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      waitCnt   <= '0;
      faultCode <= '0;
      retireCnt <= '0;
    end else begin
      state     <= stateNext;
      waitCnt   <= waitCntNext;
      faultCode <= faultCodeNext;
      if (retireInc) retireCnt <= retireCnt + CNT_W'(1);
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    alu_src_a     = 1'b0;
    load_reg_a    = 1'b0;
    load_reg_b    = 1'b0;
    load_alu_out  = 1'b0;
    write_reg     = 1'b0;
    load_ir       = 1'b0;
    load_mdr      = 1'b0;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_write    = 1'b0;
    branch_op     = 1'b0;
    pc_src        = 2'b00;
    alu_src_b     = 2'b00;
    alu_funct     = 3'b000;
    mem_to_reg    = 2'b00;
    fault         = 1'b0;
    fault_code    = 2'b00;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        load_ir  = 1'b1;
      end
      FETCH_DONE: begin
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        alu_funct = 3'b001;
      end
      DECODE: begin
        load_reg_a   = 1'b1;
        load_reg_b   = 1'b1;
        load_alu_out = 1'b1;
        alu_src_b    = 2'b11;
        alu_funct    = 3'b001;
      end
      CALC_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        alu_funct    = 3'b001;
        load_alu_out = 1'b1;
      end
      EXEC_R: begin
        alu_src_a    = 1'b1;
        load_alu_out = 1'b1;
        alu_funct    = rOp;
      end
      MEM_RD: begin
        dmem_req = 1'b1;
        load_mdr = 1'b1;
      end
      MEM_WR: begin
        dmem_req   = 1'b1;
        dmem_write = 1'b1;
      end
      WB_ALU: write_reg = 1'b1;
      WB_MEM: begin
        write_reg  = 1'b1;
        mem_to_reg = 2'b01;
      end
      LUI: begin
        write_reg  = 1'b1;
        mem_to_reg = 2'b10;
      end
      BRANCH: begin
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        alu_src_a     = 1'b1;
        alu_funct     = 3'b010;
        branch_op     = instruction[12];
      end
      JAL: begin
        write_reg  = 1'b1;
        mem_to_reg = 2'b11;
        pc_write   = 1'b1;
        pc_src     = 2'b10;
      end
      FAULT: begin
        fault      = 1'b1;
        fault_code = faultCode;
      end
      default: ;
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      alu_src_a     = 1'b0;
      load_reg_a    = 1'b0;
      load_reg_b    = 1'b0;
      load_alu_out  = 1'b0;
      write_reg     = 1'b0;
      load_ir       = 1'b0;
      load_mdr      = 1'b0;
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      dmem_write    = 1'b0;
      branch_op     = 1'b0;
      pc_src        = 2'b00;
      alu_src_b     = 2'b00;
      alu_funct     = 3'b000;
      mem_to_reg    = 2'b00;
      fault         = 1'b0;
      fault_code    = 2'b00;
    end
  end

  assign state_out  = state;
  assign retire_cnt = retireCnt;

endmodule
